data_load_arbiter: RTL and testbench
====================================

DATA_LOAD_ARBITER -- requirements
Module: data_load_arbiter

Interface
REQ-001 SHALL have parameter restart_hold, default 5: number of cycles cpu_restart is held high per session.
REQ-002 SHALL have parameter watchdog_timeout, default 1024: idle-cycle limit in STREAM; used only with the watchdog macro.
REQ-003 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cl_restart  input  2  per-client session request pulse; client 0 = pre-loader, client 1 = song loader.
REQ-006 SHALL have port cl_init_index  input  16  {client1[7:0], client0[7:0]} session index.
REQ-007 SHALL have port cl_init_aux_info  input  16  {client1, client0} aux info bytes.
REQ-008 SHALL have port cl_request_data  input  2  per-client byte request.
REQ-009 SHALL have port cl_data_ready  output  2  per-client byte-valid strobe.
REQ-010 SHALL have port cl_data_out  output  8  shared byte bus to clients.
REQ-011 SHALL have port cl_transmit_finished  output  2  per-client end-of-session level.
REQ-012 SHALL have ports cpu_restart output 1, cpu_init_index output 8, cpu_init_aux_info output 8, cpu_request_data output 1: CPU link requests.
REQ-013 SHALL have ports cpu_data_ready input 1, cpu_data_in input 8, cpu_transmit_finished input 1: CPU link responses.
REQ-014 SHALL have ports grant output 2 (one-hot owner, 0 when idle), busy output 1, timeout_err output 1.

Function
REQ-015 SHALL implement FSM IDLE -> RESTART -> STREAM -> DONE -> IDLE.
REQ-016 SHALL set pending[i] and latch that client's index/aux when cl_restart[i] is high in any cycle; repeated pulses while pending overwrite the latched values.
REQ-017 In IDLE with any pending bit, SHALL grant round-robin (client not served last wins a tie; after reset client 0 wins), clear its pending bit, and enter RESTART next cycle.
REQ-018 In RESTART SHALL drive cpu_restart=1 and cpu_init_index/aux from the latched values for exactly restart_hold cycles, then enter STREAM.
REQ-019 In STREAM SHALL route cpu_request_data = cl_request_data[owner], cl_data_ready[owner] = cpu_data_ready, cl_data_out = cpu_data_in, combinationally (zero latency); non-owners see data_ready=0.
REQ-020 On cpu_transmit_finished in STREAM SHALL enter DONE; in DONE cl_transmit_finished[owner]=1 for one cycle, then IDLE with grant=0.
REQ-021 cl_transmit_finished[i] SHALL stay high after DONE until client i's next session is granted.
REQ-022 cl_restart from the owner during RESTART/STREAM SHALL restart its session: re-latch, restart the hold counter, re-enter RESTART.
REQ-023 cl_restart from the non-owner during a session SHALL only set pending; it is served after DONE.
REQ-024 Simultaneous cl_restart[0] and cl_restart[1] in IDLE SHALL both pend; round-robin picks one, the other follows.
REQ-025 busy SHALL be 1 in every state except IDLE.

Reset
REQ-026 RESET SHALL return FSM to IDLE, clear pending, grant, counters, and set last-served to client 1 (so client 0 wins first).
REQ-027 Under reset all outputs SHALL be 0; reset mid-session SHALL abort silently, with no cl_transmit_finished pulse.

Configuration
REQ-028 With LOAD_ARB_WATCHDOG_EN defined, SHALL count STREAM cycles since the last cpu_data_ready; on reaching watchdog_timeout SHALL pulse timeout_err for 1 cycle and return to IDLE without asserting cl_transmit_finished.
REQ-029 Without LOAD_ARB_WATCHDOG_EN, no counter SHALL exist and timeout_err SHALL be tied 0.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, client-index constants (CL_PRE=0, CL_SONG=1), and the byte width 8.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter_2 (inputs pending, last; output one-hot pick); everything else is in one module.

Verification
REQ-032 cl_restart[0] pulse with index 3, restart_hold=5 -> grant=01 next cycle; cpu_restart high 5 cycles with cpu_init_index=3.
REQ-033 Client 0 streams bytes 1..12 -> cl_data_ready[0] and cl_data_out mirror the CPU link in the same cycle; cl_data_ready[1] stays 0.
REQ-034 cpu_transmit_finished -> DONE, then IDLE; cl_transmit_finished[0] stays high; grant=00.
REQ-035 Both cl_restart bits pulse in the same IDLE cycle after reset -> client 0 served first, client 1 granted one cycle after client 0's DONE.
REQ-036 cl_restart[1] during client 0 STREAM -> no disturbance to client 0; client 1 is served next. Owner re-pulse -> RESTART re-entered with the new index.
REQ-037 With LOAD_ARB_WATCHDOG_EN and watchdog_timeout=16, no data for 16 STREAM cycles -> timeout_err pulses 1 cycle, then IDLE. RESET mid-STREAM -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/data_load_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_load_arbiter_pkg
// Description : Shared definitions for the data load arbiter.
//               - FSM state encoding (explicit 2-bit width)
//               - client index constants (CL_PRE = pre-loader, CL_SONG = song loader)
//               - byte width of the data path
//               - helper function that turns a client index into a one-hot vector
// Revision    : 1.0 - initial release
// ============================================================================
package data_load_arbiter_pkg;

    localparam int BYTE_W = 8;
    localparam int NUM_CL = 2;

    localparam int CL_PRE  = 0;
    localparam int CL_SONG = 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RESTART = 2'd1;
    localparam logic [1:0] ST_STREAM  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // One-hot form of a client index (bit 0 = CL_PRE, bit 1 = CL_SONG).
    function automatic logic [NUM_CL-1:0] cl_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage : data_load_arbiter_pkg
`default_nettype wire

// File: rtl/data_load_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-requester round-robin picker (purely combinational).
//               A lone requester always wins; on a tie the client that was
//               NOT served last wins.
// Ports       : pending [1:0] in  - request vector
//               last          in  - index of the client served last
//               pick    [1:0] out - one-hot winner, 0 when nothing pending
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import data_load_arbiter_pkg::*;
(
    input  logic [1:0] pending,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        case (pending)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = cl_onehot(~last);
            default: pick = 2'b00;
        endcase
    end

endmodule : rr_arbiter_2
`default_nettype wire

// File: rtl/data_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_load_arbiter
// Description : Shares one CPU data-load link between two clients
//               (client 0 = pre-loader, client 1 = song loader).
//               FSM: IDLE -> RESTART -> STREAM -> DONE -> IDLE.
//               Session requests are latched as pending and served
//               round-robin; the CPU link is routed combinationally to the
//               owner while streaming.
// Config      : LOAD_ARB_WATCHDOG_EN - when defined, a STREAM idle watchdog
//               aborts the session after watchdog_timeout cycles without
//               cpu_data_ready and pulses timeout_err. Otherwise timeout_err
//               is tied low and no counter exists.
// Parameters  : restart_hold     - cycles cpu_restart is held per session (>=1)
//               watchdog_timeout - STREAM idle-cycle limit (watchdog build only)
// Ports       : CLK, RESET (sync, active high)
//               cl_restart[1:0], cl_init_index[15:0], cl_init_aux_info[15:0],
//               cl_request_data[1:0]                       - client requests
//               cl_data_ready[1:0], cl_data_out[7:0],
//               cl_transmit_finished[1:0]                  - client responses
//               cpu_restart, cpu_init_index[7:0], cpu_init_aux_info[7:0],
//               cpu_request_data                           - CPU link requests
//               cpu_data_ready, cpu_data_in[7:0],
//               cpu_transmit_finished                      - CPU link responses
//               grant[1:0], busy, timeout_err              - status
// Revision    : 1.0 - initial release
// ============================================================================
module data_load_arbiter
    import data_load_arbiter_pkg::*;
#(
    parameter int restart_hold     = 5,
    parameter int watchdog_timeout = 1024
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [1:0]               cl_restart,
    input  logic [15:0]              cl_init_index,
    input  logic [15:0]              cl_init_aux_info,
    input  logic [1:0]               cl_request_data,
    output logic [1:0]               cl_data_ready,
    output logic [BYTE_W-1:0]        cl_data_out,
    output logic [1:0]               cl_transmit_finished,
    output logic                     cpu_restart,
    output logic [BYTE_W-1:0]        cpu_init_index,
    output logic [BYTE_W-1:0]        cpu_init_aux_info,
    output logic                     cpu_request_data,
    input  logic                     cpu_data_ready,
    input  logic [BYTE_W-1:0]        cpu_data_in,
    input  logic                     cpu_transmit_finished,
    output logic [1:0]               grant,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int HOLD_W = (restart_hold > 1) ? $clog2(restart_hold) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]                     r_state;
    logic                           r_owner;
    logic                           r_last;
    logic [1:0]                     r_pending;
    logic [1:0][BYTE_W-1:0]         r_index;
    logic [1:0][BYTE_W-1:0]         r_aux;
    logic [HOLD_W-1:0]              r_hold;
    logic [1:0]                     r_fin;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       w_live;
    logic       w_idle;
    logic       w_in_session;
    logic [1:0] w_owner_oh;
    logic       w_owner_restart;
    logic [1:0] w_arb_req;
    logic [1:0] w_pick;
    logic       w_grant_now;
    logic       w_pick_idx;
    logic       w_hold_done;
    logic [1:0] w_pending_nxt;
    logic       w_restart_on;
    logic       w_stream_on;
    logic       w_wd_hit;

    // Outputs are forced low while RESET is asserted, not only after the edge.
    assign w_live       = ~RESET;
    assign w_idle       = (r_state == ST_IDLE);
    assign w_in_session = (r_state == ST_RESTART) || (r_state == ST_STREAM);
    assign w_owner_oh   = cl_onehot(r_owner);

    // The owner re-requesting mid-session restarts its own session instead
    // of queueing behind itself.
    assign w_owner_restart = w_in_session && cl_restart[r_owner];

    // Requests arriving in an IDLE cycle compete immediately, so a single
    // pulse is granted on the very next cycle.
    assign w_arb_req = w_idle ? (r_pending | cl_restart) : 2'b00;

    rr_arbiter_2 u_rr (
        .pending (w_arb_req),
        .last    (r_last),
        .pick    (w_pick)
    );

    assign w_grant_now = |w_pick;
    assign w_pick_idx  = w_pick[1];
    assign w_hold_done = (r_hold == HOLD_W'(restart_hold - 1));

    assign w_pending_nxt = (r_pending
                            | (cl_restart & ~(w_owner_restart ? w_owner_oh : 2'b00)))
                           & ~w_pick;

    // ------------------------------------------------------------------
    // Main FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'(CL_SONG);
            r_pending <= 2'b00;
            r_index   <= '0;
            r_aux     <= '0;
            r_hold    <= '0;
            r_fin     <= 2'b00;
        end else begin
            r_pending <= w_pending_nxt;

            for (int i = 0; i < NUM_CL; i++) begin
                if (cl_restart[i]) begin
                    r_index[i] <= cl_init_index[i*BYTE_W +: BYTE_W];
                    r_aux[i]   <= cl_init_aux_info[i*BYTE_W +: BYTE_W];
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_now) begin
                        r_state           <= ST_RESTART;
                        r_owner           <= w_pick_idx;
                        r_last            <= w_pick_idx;
                        r_hold            <= '0;
                        r_fin[w_pick_idx] <= 1'b0;
                    end
                end
                ST_RESTART: begin
                    if (w_owner_restart) begin
                        r_hold <= '0;
                    end else if (w_hold_done) begin
                        r_state <= ST_STREAM;
                        r_hold  <= '0;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (w_owner_restart) begin
                        r_state <= ST_RESTART;
                        r_hold  <= '0;
                    end else if (cpu_transmit_finished) begin
                        r_state        <= ST_DONE;
                        r_fin[r_owner] <= 1'b1;
                    end else if (w_wd_hit) begin
                        // Aborted session: no finished indication.
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional STREAM idle watchdog
    // ------------------------------------------------------------------
`ifdef LOAD_ARB_WATCHDOG_EN
    localparam int WD_W = (watchdog_timeout > 1) ? $clog2(watchdog_timeout) : 1;

    logic [WD_W-1:0] r_wd;
    logic            r_timeout;
    logic            w_wd_count;

    assign w_wd_count = (r_state == ST_STREAM) && !w_owner_restart
                        && !cpu_transmit_finished && !cpu_data_ready;
    assign w_wd_hit   = w_wd_count && (r_wd == WD_W'(watchdog_timeout - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_wd_hit;
            if (w_wd_count && !w_wd_hit) begin
                r_wd <= r_wd + WD_W'(1);
            end else begin
                r_wd <= '0;
            end
        end
    end

    assign timeout_err = w_live & r_timeout;
`else
    logic w_unused_wd_cfg;

    assign w_unused_wd_cfg = (watchdog_timeout != 0);
    assign w_wd_hit        = 1'b0;
    assign timeout_err     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_restart_on = w_live && (r_state == ST_RESTART);
    assign w_stream_on  = w_live && (r_state == ST_STREAM);

    assign busy  = w_live && !w_idle;
    assign grant = (w_live && !w_idle) ? w_owner_oh : 2'b00;

    assign cpu_restart       = w_restart_on;
    assign cpu_init_index    = w_restart_on ? r_index[r_owner] : '0;
    assign cpu_init_aux_info = w_restart_on ? r_aux[r_owner]   : '0;

    // Zero-latency routing between the CPU link and the owning client.
    assign cpu_request_data = w_stream_on && cl_request_data[r_owner];
    assign cl_data_ready    = (w_stream_on && cpu_data_ready) ? w_owner_oh : 2'b00;
    assign cl_data_out      = w_stream_on ? cpu_data_in : '0;

    assign cl_transmit_finished = w_live ? r_fin : 2'b00;

endmodule : data_load_arbiter
`default_nettype wire

// File: tb/tb_data_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_load_arbiter
// Description : Self-checking bench for data_load_arbiter (restart_hold = 5,
//               watchdog_timeout = 16). Streaming bytes are tracked with a
//               queue: expected bytes are pushed when driven on the CPU link
//               and popped when the owner's data_ready strobe appears.
//               Watchdog scenario runs when LOAD_ARB_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_load_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  cl_restart;
    logic [15:0] cl_init_index;
    logic [15:0] cl_init_aux_info;
    logic [1:0]  cl_request_data;
    logic [1:0]  cl_data_ready;
    logic [7:0]  cl_data_out;
    logic [1:0]  cl_transmit_finished;
    logic        cpu_restart;
    logic [7:0]  cpu_init_index;
    logic [7:0]  cpu_init_aux_info;
    logic        cpu_request_data;
    logic        cpu_data_ready;
    logic [7:0]  cpu_data_in;
    logic        cpu_transmit_finished;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout_err;

    data_load_arbiter #(
        .restart_hold     (5),
        .watchdog_timeout (16)
    ) dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .cl_restart            (cl_restart),
        .cl_init_index         (cl_init_index),
        .cl_init_aux_info      (cl_init_aux_info),
        .cl_request_data       (cl_request_data),
        .cl_data_ready         (cl_data_ready),
        .cl_data_out           (cl_data_out),
        .cl_transmit_finished  (cl_transmit_finished),
        .cpu_restart           (cpu_restart),
        .cpu_init_index        (cpu_init_index),
        .cpu_init_aux_info     (cpu_init_aux_info),
        .cpu_request_data      (cpu_request_data),
        .cpu_data_ready        (cpu_data_ready),
        .cpu_data_in           (cpu_data_in),
        .cpu_transmit_finished (cpu_transmit_finished),
        .grant                 (grant),
        .busy                  (busy),
        .timeout_err           (timeout_err)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    logic seen_timeout = 1'b0;

    always @(negedge CLK) if (timeout_err === 1'b1) seen_timeout <= 1'b1;

    typedef struct {
        logic       req0;
        logic       req1;
        logic       rdy;
        logic [7:0] data;
        logic [1:0] exp_rdy;
        logic       exp_req;
    } vec_t;

    vec_t       tbl[16];
    logic [7:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic [1:0] which, input logic [15:0] idx, input logic [15:0] aux);
        cl_restart       = which;
        cl_init_index    = idx;
        cl_init_aux_info = aux;
        step();
        cl_restart = 2'b00;
    endtask

    // Counts consecutive cpu_restart cycles, starting at the current cycle.
    task automatic count_restart(input logic [7:0] exp_idx, output int n, output logic bad);
        n   = 0;
        bad = 1'b0;
        while (cpu_restart === 1'b1 && n < 20) begin
            if (cpu_init_index !== exp_idx) bad = 1'b1;
            n++;
            step();
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {30'd0, grant, busy, timeout_err, cpu_restart, cpu_init_index,
                cpu_init_aux_info, cpu_request_data, cl_data_ready, cl_data_out,
                cl_transmit_finished};
    endfunction

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int         n;
        logic       bad;
        int         rcv;
        logic [7:0] nb;

        RESET                 = 1'b1;
        cl_restart            = 2'b00;
        cl_init_index         = 16'h0;
        cl_init_aux_info      = 16'h0;
        cl_request_data       = 2'b00;
        cpu_data_ready        = 1'b0;
        cpu_data_in           = 8'h0;
        cpu_transmit_finished = 1'b0;

        // Stream table: bytes 1..12 with an idle slot every fourth row.
        nb = 8'd0;
        for (int k = 0; k < 16; k++) begin
            tbl[k].req0    = (k % 3 != 2);
            tbl[k].req1    = (k % 3 == 2);
            tbl[k].rdy     = (k % 4 != 3);
            if (tbl[k].rdy) nb = nb + 8'd1;
            tbl[k].data    = tbl[k].rdy ? nb : 8'hEE;
            tbl[k].exp_rdy = tbl[k].rdy ? 2'b01 : 2'b00;
            tbl[k].exp_req = tbl[k].req0;
        end

        // ---------------- reset ----------------
        step();
        chk("reset_outputs", all_outs(), 64'd0);
        step();
        RESET = 1'b0;
        step();
        chk("idle_grant", {62'd0, grant}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // ---------------- client 0 session ----------------
        pulse(2'b01, 16'h0003, 16'h00A5);
        chk("c0_grant", {62'd0, grant}, 64'd1);
        chk("c0_aux", {56'd0, cpu_init_aux_info}, 64'hA5);
        count_restart(8'd3, n, bad);
        chk("c0_hold_cycles", 64'(n), 64'd5);
        chk("c0_hold_index", {63'd0, bad}, 64'd0);

        rcv = 0;
        for (int k = 0; k < 16; k++) begin
            cl_restart      = (k == 6) ? 2'b10 : 2'b00;
            cl_init_index   = (k == 6) ? 16'h7700 : 16'h0000;
            cl_request_data = {tbl[k].req1, tbl[k].req0};
            cpu_data_ready  = tbl[k].rdy;
            cpu_data_in     = tbl[k].data;
            if (tbl[k].rdy) sb.push_back(tbl[k].data);
            #1;
            chk("stream_ready", {62'd0, cl_data_ready}, {62'd0, tbl[k].exp_rdy});
            chk("stream_req", {63'd0, cpu_request_data}, {63'd0, tbl[k].exp_req});
            if (cl_data_ready[0] === 1'b1) begin
                rcv++;
                if (sb.size() == 0) chk("stream_underflow", 64'd1, 64'd0);
                else chk("stream_byte", {56'd0, cl_data_out}, {56'd0, sb.pop_front()});
            end
            @(posedge CLK);
            #1;
        end
        cl_restart      = 2'b00;
        cpu_data_ready  = 1'b0;
        cl_request_data = 2'b00;
        chk("stream_count", 64'(rcv), 64'd12);
        chk("stream_sb_empty", 64'(sb.size()), 64'd0);
        chk("c0_still_owner", {62'd0, grant}, 64'd1);

        cpu_transmit_finished = 1'b1;
        step();
        cpu_transmit_finished = 1'b0;
        chk("done_busy", {63'd0, busy}, 64'd1);
        chk("done_fin", {62'd0, cl_transmit_finished}, 64'd1);
        step();
        chk("after_done_grant", {62'd0, grant}, 64'd0);
        chk("after_done_busy", {63'd0, busy}, 64'd0);
        chk("after_done_fin", {62'd0, cl_transmit_finished}, 64'd1);
        step();
        chk("c1_grant", {62'd0, grant}, 64'd2);
        chk("c1_index", {56'd0, cpu_init_index}, 64'h77);
        chk("c1_fin_keep", {62'd0, cl_transmit_finished}, 64'd1);

        // ---------------- client 1 session with owner restart ----------------
        count_restart(8'h77, n, bad);
        chk("c1_hold_cycles", 64'(n), 64'd5);
        cpu_data_ready  = 1'b1;
        cpu_data_in     = 8'h5A;
        cl_request_data = 2'b01;
        #1;
        chk("c1_ready_route", {62'd0, cl_data_ready}, 64'd2);
        chk("c1_data_route", {56'd0, cl_data_out}, 64'h5A);
        chk("c1_req_other", {63'd0, cpu_request_data}, 64'd0);
        cl_request_data = 2'b10;
        #1;
        chk("c1_req_owner", {63'd0, cpu_request_data}, 64'd1);
        cpu_data_ready  = 1'b0;
        cl_request_data = 2'b00;
        pulse(2'b10, 16'h5500, 16'h0000);
        chk("c1_rerestart", {63'd0, cpu_restart}, 64'd1);
        chk("c1_rerestart_idx", {56'd0, cpu_init_index}, 64'h55);
        count_restart(8'h55, n, bad);
        chk("c1_rehold_cycles", 64'(n), 64'd5);
        chk("c1_rehold_index", {63'd0, bad}, 64'd0);
        cpu_transmit_finished = 1'b1;
        step();
        cpu_transmit_finished = 1'b0;
        step();
        chk("both_fin", {62'd0, cl_transmit_finished}, 64'd3);

        // ---------------- simultaneous requests after reset ----------------
        RESET = 1'b1;
        step();
        chk("reset2_outputs", all_outs(), 64'd0);
        RESET = 1'b0;
        pulse(2'b11, 16'h2010, 16'h0000);
        chk("tie_grant", {62'd0, grant}, 64'd1);
        chk("tie_index", {56'd0, cpu_init_index}, 64'h10);
        count_restart(8'h10, n, bad);
        cpu_transmit_finished = 1'b1;
        step();
        cpu_transmit_finished = 1'b0;
        step();
        chk("tie_gap_grant", {62'd0, grant}, 64'd0);
        step();
        chk("tie_second_grant", {62'd0, grant}, 64'd2);
        chk("tie_second_index", {56'd0, cpu_init_index}, 64'h20);

        // ---------------- reset mid-STREAM ----------------
        count_restart(8'h20, n, bad);
        cpu_data_ready = 1'b1;
        cpu_data_in    = 8'h33;
        #1;
        chk("pre_reset_ready", {62'd0, cl_data_ready}, 64'd2);
        RESET = 1'b1;
        #1;
        chk("in_reset_outputs", all_outs(), 64'd0);
        step();
        chk("after_reset_outputs", all_outs(), 64'd0);
        RESET          = 1'b0;
        cpu_data_ready = 1'b0;
        step();
        chk("abort_no_fin", {62'd0, cl_transmit_finished}, 64'd0);

`ifdef LOAD_ARB_WATCHDOG_EN
        // ---------------- watchdog ----------------
        pulse(2'b01, 16'h0009, 16'h0000);
        count_restart(8'h09, n, bad);
        n = 0;
        while (busy === 1'b1 && timeout_err !== 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("wd_cycles", 64'(n), 64'd16);
        chk("wd_pulse", {63'd0, timeout_err}, 64'd1);
        chk("wd_idle", {63'd0, busy}, 64'd0);
        chk("wd_no_fin", {62'd0, cl_transmit_finished}, 64'd0);
        step();
        chk("wd_pulse_end", {63'd0, timeout_err}, 64'd0);
`else
        chk("no_timeout_err", {63'd0, seen_timeout}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_data_load_arbiter
`default_nettype wire
